// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: HI/LO function codes, FSM states and two's-complement negate helper
package mips_muldiv_pkg;
  localparam int WORD = 32;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;
  function automatic logic [WORD-1:0] neg32(input logic [WORD-1:0] x);
    return ~x + WORD'(1);
  endfunction
endpackage

// File: rtl/mips_muldiv.sv
// mips_muldiv: multi-cycle shift-add multiply / restoring divide unit owning HI and LO
import mips_muldiv_pkg::*;
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITER = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(ITER);
  muldiv_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] a_mag, b_mag, a_in, b_in, quo, rem_src, fix_hi, fix_lo;
  logic [WIDTH:0] mul_sum, rem_sh, rem_sub;
  logic neg_q, neg_r, op_div, div0, is_signed, is_div, issue, last, busy_n, done_n;
  // decode the issued code and form operand magnitudes
  always_comb begin
    is_signed = fncode == FUNCT_MULT || fncode == FUNCT_DIV;
    is_div = fncode == FUNCT_DIV || fncode == FUNCT_DIVU;
    issue = start && state == IDLE && (is_signed || is_div || fncode == FUNCT_MULTU);
    a_in = is_signed && op_a[WIDTH-1] ? neg32(op_a) : op_a;
    b_in = is_signed && op_b[WIDTH-1] ? neg32(op_b) : op_b;
  end
  // next state: one pass of ITER iterations then a single fix-up cycle
  always_comb begin
    last = cnt == CW'(ITER - 1);
    state_n = state == IDLE ? (issue ? (is_div ? DIV : MUL) : IDLE)
            : state == FIX ? IDLE : last ? FIX : state;
  end
  // registered status outputs are computed from the coming state
  always_comb begin
    busy_n = state_n != IDLE;
    done_n = state == FIX;
  end
  // one multiply or divide step, and the signed fix-up of the final result
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? a_mag : {WIDTH{1'b0}}};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_mag};
    acc_n = state == MUL ? {mul_sum, acc[WIDTH-1:1]}
          : {rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0], acc[WIDTH-2:0], ~rem_sub[WIDTH]};
    quo = acc[WIDTH-1:0];
    rem_src = div0 ? a_mag : acc[2*WIDTH-1:WIDTH];
    fix_hi = op_div ? (neg_r ? neg32(rem_src) : rem_src)
           : neg_q ? ~acc[2*WIDTH-1:WIDTH] + WIDTH'(quo == '0) : acc[2*WIDTH-1:WIDTH];
    fix_lo = op_div && div0 ? '1 : neg_q ? neg32(quo) : quo;
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // operand latch, iteration, HI/LO writes and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      busy <= busy_n;
      done <= done_n;
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      if (issue) begin
        a_mag <= a_in;
        b_mag <= b_in;
        neg_q <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        neg_r <= is_signed && op_a[WIDTH-1];
        op_div <= is_div;
        div0 <= op_b == '0;
        acc <= {{WIDTH{1'b0}}, is_div ? a_in : b_in};
      end
      if (state == MUL || state == DIV) acc <= acc_n;
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
      if (state == IDLE && start && fncode == FUNCT_MTHI) hi <= op_a;
      if (state == IDLE && start && fncode == FUNCT_MTLO) lo <= op_a;
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: random and directed checks of the HI/LO unit against an arithmetic model
module tb_mips_muldiv;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0] fncode = 6'h0;
  logic [31:0] op_a = '0, op_b = '0, hi, lo;
  logic busy, done;
  int passed = 0, total = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
  logic m_busy = 1'b0, m_done = 1'b0;
  int remain = 0;

  mips_muldiv dut (.clk(clk), .reset(reset), .start(start), .fncode(fncode), .op_a(op_a),
                   .op_b(op_b), .hi(hi), .lo(lo), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h18: return sa * sb;
      6'h19: return {32'h0, a} * {32'h0, b};
      6'h1A: return b == 0 ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      6'h1B: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return 64'h0;
    endcase
  endfunction

  // model: a mul/div lands 33 edges after acceptance; MTHI/MTLO land immediately when idle
  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; remain = 0;
    end else begin
      m_done = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        if (fncode inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
          {p_hi, p_lo} = ref_op(fncode, op_a, op_b);
          remain = 33;
          m_busy = 1'b1;
        end else if (fncode == 6'h11) m_hi = op_a;
        else if (fncode == 6'h13) m_lo = op_a;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("hi", {32'h0, hi}, {32'h0, m_hi});
    chk("lo", {32'h0, lo}, {32'h0, m_lo});
    chk("busy", {63'h0, busy}, {63'h0, m_busy});
    chk("done", {63'h0, done}, {63'h0, m_done});
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; fncode = f; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; fncode = 6'h0;
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'd33);
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(f, a, b);
    wait_done(name);
    chk({name, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    logic [5:0] codes [9];
    logic [31:0] specials [5];
    logic [31:0] ra, rb;
    codes = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12, 6'h00};
    specials = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF};
    chk("model_multu", ref_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model_div", ref_op(6'h1A, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", {hi, lo, 31'h0, busy, 31'h0, done}, 128'h0);
    run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min", 6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 6'h1A, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    issue(6'h11, 32'h1234_5678, 32'h0);
    chk("mthi", {32'h0, hi}, {32'h0, 32'h1234_5678});
    issue(6'h13, 32'hCAFE_F00D, 32'h0);
    chk("mtlo", {32'h0, lo}, {32'h0, 32'hCAFE_F00D});
    issue(6'h19, 32'd1000, 32'd1000);
    repeat (3) @(negedge clk);
    issue(6'h19, 32'd7, 32'd9);
    issue(6'h11, 32'hDEAD_BEEF, 32'h0);
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    chk("busy_ignore", {hi, lo}, {32'h0, 32'd1000000});
    issue(6'h19, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort", {hi, lo, 31'h0, busy, 31'h0, done}, 128'h0);
    run_op("after_abort", 6'h19, 32'd3, 32'd4, 32'd0, 32'd12);
    for (int n = 0; n < 60; n++) begin
      ra = $urandom_range(0, 3) == 0 ? specials[$urandom_range(0, 4)] : $urandom;
      rb = $urandom_range(0, 3) == 0 ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      issue(codes[$urandom_range(0, 8)], ra, rb);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
